// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM-to-WB pipeline register with big-endian load-data alignment,
// misalignment suppression, stall/flush handling and a retired-instruction counter.
// All wb_* outputs come straight from flops so the register file can bypass them safely.
module mem_wb_stage #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_mem,
  input  logic                stall_wb,
  input  logic                flush,
  input  logic                mem_valid,
  input  logic                mem_we,
  input  logic [4:0]          mem_waddr,
  input  logic [31:0]         mem_wdata,
  input  logic                mem_is_load,
  input  logic [2:0]          mem_load_op,
  input  logic [1:0]          mem_addr_lo,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_hilo_we,
  input  logic [31:0]         mem_hi,
  input  logic [31:0]         mem_lo,
  output logic                wb_we,
  output logic [4:0]          wb_waddr,
  output logic [31:0]         wb_wdata,
  output logic                wb_hilo_we,
  output logic [31:0]         wb_hi,
  output logic [31:0]         wb_lo,
  output logic                wb_misalign,
  output logic [RETIRE_W-1:0] retire_cnt
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;
  logic        load_bad;
  logic        cap_misalign;
  logic [31:0] cap_wdata;

  // Pick the big-endian byte and halfword lanes addressed by the low address bits.
  always_comb begin
    sel_byte = 8'h00;
    case (mem_addr_lo)
      2'b00: sel_byte = mem_rdata[31:24];
      2'b01: sel_byte = mem_rdata[23:16];
      2'b10: sel_byte = mem_rdata[15:8];
      2'b11: sel_byte = mem_rdata[7:0];
      default: sel_byte = 8'h00;
    endcase
    sel_half = mem_addr_lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  end

  // Extend the selected lane per load type and flag misaligned or reserved loads.
  always_comb begin
    load_data = 32'h0;
    load_bad  = 1'b0;
    case (mem_load_op)
      OP_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU: load_data = {24'h0, sel_byte};
      OP_LH: begin
        load_bad  = mem_addr_lo[0];
        load_data = {{16{sel_half[15]}}, sel_half};
      end
      OP_LHU: begin
        load_bad  = mem_addr_lo[0];
        load_data = {16'h0, sel_half};
      end
      OP_LW: begin
        load_bad  = (mem_addr_lo != 2'b00);
        load_data = mem_rdata;
      end
      default: load_bad = 1'b1;
    endcase
  end

  // Choose the value that will be captured into wb_wdata; a faulting load writes zero.
  always_comb begin
    cap_misalign = mem_is_load & load_bad;
    if (!mem_is_load)
      cap_wdata = mem_wdata;
    else if (load_bad)
      cap_wdata = 32'h0;
    else
      cap_wdata = load_data;
  end

  // Pipeline register: reset, then flush/bubble, then hold on WB stall, else capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we       <= 1'b0;
      wb_waddr    <= 5'd0;
      wb_wdata    <= 32'h0;
      wb_hilo_we  <= 1'b0;
      wb_hi       <= 32'h0;
      wb_lo       <= 32'h0;
      wb_misalign <= 1'b0;
      retire_cnt  <= '0;
    end else if (flush || (stall_mem && !stall_wb)) begin
      wb_we       <= 1'b0;
      wb_waddr    <= 5'd0;
      wb_wdata    <= 32'h0;
      wb_hilo_we  <= 1'b0;
      wb_hi       <= 32'h0;
      wb_lo       <= 32'h0;
      wb_misalign <= 1'b0;
    end else if (!stall_wb) begin
      wb_we       <= mem_we & mem_valid & ~cap_misalign;
      wb_waddr    <= mem_waddr;
      wb_wdata    <= cap_wdata;
      wb_hilo_we  <= mem_hilo_we & mem_valid;
      wb_hi       <= mem_hi;
      wb_lo       <= mem_lo;
      wb_misalign <= cap_misalign & mem_valid;
      if (mem_valid)
        retire_cnt <= retire_cnt + RETIRE_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: vector table for load alignment, directed stall/flush/wrap
// sequences, and randomized traffic against a behavioural model of the WB stage.
module tb_mem_wb_stage;

  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst, stall_mem, stall_wb, flush, mem_valid, mem_we;
  logic [4:0]    mem_waddr;
  logic [31:0]   mem_wdata;
  logic          mem_is_load;
  logic [2:0]    mem_load_op;
  logic [1:0]    mem_addr_lo;
  logic [31:0]   mem_rdata;
  logic          mem_hilo_we;
  logic [31:0]   mem_hi, mem_lo;
  logic          wb_we, wb_hilo_we, wb_misalign;
  logic [4:0]    wb_waddr;
  logic [31:0]   wb_wdata, wb_hi, wb_lo;
  logic [RW-1:0] retire_cnt;

  // Expected WB state held by the model.
  logic        e_we, e_hilo_we, e_mis, e_mis_care;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata, e_hi, e_lo;
  int          e_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        is_load;
    logic [2:0]  op;
    logic [1:0]  a;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [31:0] x_wdata;
    logic        x_we;
    logic        x_mis;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  mem_wb_stage #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_is_load(mem_is_load), .mem_load_op(mem_load_op), .mem_addr_lo(mem_addr_lo),
    .mem_rdata(mem_rdata), .mem_hilo_we(mem_hilo_we), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_hilo_we(wb_hilo_we),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_misalign(wb_misalign), .retire_cnt(retire_cnt)
  );

  // Reference load result: {misaligned, data}, from byte arithmetic on the word.
  function automatic logic [32:0] refLoad(input logic [2:0] op, input logic [1:0] a,
                                          input logic [31:0] w);
    longint b, h;
    b = (longint'(w) >> (8 * (3 - int'(a)))) & 255;
    h = (longint'(w) >> (16 * (1 - int'(a) / 2))) & 65535;
    case (op)
      3'd0: return {1'b0, 32'(b >= 128 ? b - 256 : b)};
      3'd1: return {1'b0, 32'(b)};
      3'd2: return (a % 2 == 1) ? 33'h1_0000_0000 : {1'b0, 32'(h >= 32768 ? h - 65536 : h)};
      3'd3: return (a % 2 == 1) ? 33'h1_0000_0000 : {1'b0, 32'(h)};
      3'd4: return (a != 0) ? 33'h1_0000_0000 : {1'b0, w};
      default: return 33'h1_0000_0000;
    endcase
  endfunction

  // Advance the model by one clock edge using the current input values.
  task automatic modelEdge();
    logic [32:0] r;
    logic        m;
    if (rst) begin
      {e_we, e_hilo_we, e_mis} = 3'b000; e_waddr = 0; e_wdata = 0; e_hi = 0; e_lo = 0;
      e_cnt = 0; e_mis_care = 1'b1;
    end else if (flush || (stall_mem && !stall_wb)) begin
      {e_we, e_hilo_we, e_mis} = 3'b000; e_waddr = 0; e_wdata = 0; e_hi = 0; e_lo = 0;
      e_mis_care = 1'b1;
    end else if (!stall_wb) begin
      r = refLoad(mem_load_op, mem_addr_lo, mem_rdata);
      m = mem_is_load && r[32];
      e_we = mem_we && mem_valid && !m;
      e_waddr = mem_waddr;
      e_wdata = !mem_is_load ? mem_wdata : (m ? 32'h0 : r[31:0]);
      e_hilo_we = mem_hilo_we && mem_valid;
      e_hi = mem_hi; e_lo = mem_lo;
      e_mis = m && mem_valid;
      e_mis_care = mem_valid;
      if (mem_valid) e_cnt = (e_cnt + 1) % (1 << RW);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    chk("wb_we", 32'(wb_we), 32'(e_we));
    chk("wb_waddr", 32'(wb_waddr), 32'(e_waddr));
    chk("wb_wdata", wb_wdata, e_wdata);
    chk("wb_hilo_we", 32'(wb_hilo_we), 32'(e_hilo_we));
    chk("wb_hi", wb_hi, e_hi);
    chk("wb_lo", wb_lo, e_lo);
    if (e_mis_care) chk("wb_misalign", 32'(wb_misalign), 32'(e_mis));
    chk("retire_cnt", 32'(retire_cnt), 32'(e_cnt));
  endtask

  // One clock: model the edge, let the DUT take it, then compare 1 time unit later.
  task automatic applyStimulus();
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic randInputs();
    mem_valid = 1'($urandom); mem_we = 1'($urandom); mem_waddr = 5'($urandom);
    mem_wdata = $urandom; mem_is_load = 1'($urandom); mem_load_op = 3'($urandom_range(0, 5));
    mem_addr_lo = 2'($urandom); mem_rdata = $urandom; mem_hilo_we = 1'($urandom);
    mem_hi = $urandom; mem_lo = $urandom;
  endtask

  task automatic plainInst(input logic [4:0] wa, input logic [31:0] wd);
    mem_valid = 1; mem_we = 1; mem_waddr = wa; mem_wdata = wd; mem_is_load = 0;
    mem_load_op = 0; mem_addr_lo = 0; mem_rdata = 0; mem_hilo_we = 0; mem_hi = 0; mem_lo = 0;
  endtask

  initial begin
    vecs[0]  = '{1, 3'd0, 2'd0, 32'h80FF_7F01, 32'h0, 32'hFFFF_FF80, 1, 0};
    vecs[1]  = '{1, 3'd1, 2'd1, 32'h80FF_7F01, 32'h0, 32'h0000_00FF, 1, 0};
    vecs[2]  = '{1, 3'd0, 2'd2, 32'h80FF_7F01, 32'h0, 32'h0000_007F, 1, 0};
    vecs[3]  = '{1, 3'd2, 2'd0, 32'h80FF_7F01, 32'h0, 32'hFFFF_80FF, 1, 0};
    vecs[4]  = '{1, 3'd3, 2'd2, 32'h80FF_7F01, 32'h0, 32'h0000_7F01, 1, 0};
    vecs[5]  = '{1, 3'd4, 2'd0, 32'h80FF_7F01, 32'h0, 32'h80FF_7F01, 1, 0};
    vecs[6]  = '{1, 3'd4, 2'd1, 32'h80FF_7F01, 32'h0, 32'h0000_0000, 0, 1};
    vecs[7]  = '{1, 3'd2, 2'd3, 32'h80FF_7F01, 32'h0, 32'h0000_0000, 0, 1};
    vecs[8]  = '{1, 3'd6, 2'd0, 32'h80FF_7F01, 32'h0, 32'h0000_0000, 0, 1};
    vecs[9]  = '{0, 3'd4, 2'd3, 32'h80FF_7F01, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0};
    vecs[10] = '{1, 3'd1, 2'd3, 32'h80FF_7F01, 32'h0, 32'h0000_0001, 1, 0};

    stall_mem = 0; stall_wb = 0; flush = 0;
    e_cnt = 0; e_mis_care = 1;

    // Reset with random inputs for two edges.
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      randInputs();
      stall_mem = 1'($urandom); stall_wb = 1'($urandom); flush = 1'($urandom);
      applyStimulus();
    end
    chk("reset_cnt", 32'(retire_cnt), 32'h0);
    rst = 0; stall_mem = 0; stall_wb = 0; flush = 0;

    // First capture after reset.
    plainInst(5'd5, 32'h1234_5678);
    applyStimulus();
    chk("first_wdata", wb_wdata, 32'h1234_5678);
    chk("first_cnt", 32'(retire_cnt), 32'd1);

    // Load alignment table.
    for (int i = 0; i < 11; i++) begin
      plainInst(5'(i + 1), vecs[i].wdata);
      mem_is_load = vecs[i].is_load; mem_load_op = vecs[i].op;
      mem_addr_lo = vecs[i].a; mem_rdata = vecs[i].rdata;
      applyStimulus();
      chk($sformatf("vec%0d_wdata", i), wb_wdata, vecs[i].x_wdata);
      chk($sformatf("vec%0d_we", i), 32'(wb_we), 32'(vecs[i].x_we));
      chk($sformatf("vec%0d_mis", i), 32'(wb_misalign), 32'(vecs[i].x_mis));
    end

    // Misaligned LW then an aligned instruction clears the flag.
    plainInst(5'd9, 32'h0); mem_is_load = 1; mem_load_op = 3'd4; mem_addr_lo = 2'd1;
    mem_rdata = 32'hDEAD_BEEF;
    applyStimulus();
    chk("mis_flag", 32'(wb_misalign), 32'h1);
    plainInst(5'd10, 32'h5555_AAAA);
    applyStimulus();
    chk("mis_clear", 32'(wb_misalign), 32'h0);

    // MEM-only stall inserts a bubble.
    plainInst(5'd11, 32'h1111_2222); mem_hilo_we = 1; stall_mem = 1;
    applyStimulus();
    chk("bubble_we", 32'(wb_we), 32'h0);
    chk("bubble_hilo", 32'(wb_hilo_we), 32'h0);
    stall_mem = 0;

    // Capture a HI/LO write, then hold it under full stall for 3 cycles.
    plainInst(5'd12, 32'h3333_4444); mem_hilo_we = 1; mem_hi = 32'hAAAA_0001; mem_lo = 32'hBBBB_0002;
    applyStimulus();
    stall_mem = 1; stall_wb = 1;
    for (int i = 0; i < 3; i++) begin
      randInputs();
      applyStimulus();
      chk("hold_hi", wb_hi, 32'hAAAA_0001);
    end
    stall_mem = 0; stall_wb = 0;
    plainInst(5'd13, 32'h7777_8888);
    applyStimulus();

    // Flush beats a WB stall with a valid HI/LO write pending.
    plainInst(5'd14, 32'h9999_0000); mem_hilo_we = 1; flush = 1; stall_wb = 1;
    applyStimulus();
    chk("flush_hilo", 32'(wb_hilo_we), 32'h0);
    flush = 0; stall_wb = 0;

    // Counter wrap.
    for (int i = 0; i < 300 && e_cnt != (1 << RW) - 1; i++) begin
      plainInst(5'($urandom), $urandom);
      applyStimulus();
    end
    chk("cnt_at_max", 32'(retire_cnt), 32'((1 << RW) - 1));
    plainInst(5'd1, 32'h1);
    applyStimulus();
    chk("cnt_wrap", 32'(retire_cnt), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      randInputs();
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall_mem = ($urandom_range(0, 4) == 0);
      stall_wb = ($urandom_range(0, 4) == 0);
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-to-writeback pipeline register and load-data aligner for the 5-stage MIPS core. It captures the MEM-stage result at the rising clock edge. It extracts and sign- or zero-extends the addressed byte or halfword from the raw data-memory word. It then drives the write port (`we`/`waddr`/`wdata`) of the general register file and the HI/LO write port. It also honours the controller's stall and flush requests and keeps a 32-bit retired-instruction counter.

## Interface
Parameters:
- `RETIRE_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall_mem`  in  1  MEM stage stalled by controller.
- `stall_wb`  in  1  WB stage stalled by controller.
- `flush`  in  1  exception/flush request; kills the instruction entering WB.
- `mem_valid`  in  1  MEM holds a real instruction (not a bubble).
- `mem_we`  in  1  instruction writes a GPR.
- `mem_waddr`  in  5  destination GPR.
- `mem_wdata`  in  32  non-load result.
- `mem_is_load`  in  1  instruction is a load.
- `mem_load_op`  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; others reserved.
- `mem_addr_lo`  in  2  effective address bits [1:0].
- `mem_rdata`  in  32  raw word from data memory, valid in the same cycle.
- `mem_hilo_we`  in  1  instruction writes HI/LO.
- `mem_hi`, `mem_lo`  in  32 each  HI/LO values.
- `wb_we`  out  1  GPR write enable to register file.
- `wb_waddr`  out  5  GPR write address.
- `wb_wdata`  out  32  GPR write data.
- `wb_hilo_we`  out  1  HI/LO write enable.
- `wb_hi`, `wb_lo`  out  32 each  HI/LO write data.
- `wb_misalign`  out  1  the captured load was misaligned and its write was suppressed.
- `retire_cnt`  out  RETIRE_W  number of valid instructions latched into WB.

## Operation
- Byte order is big-endian.
  - LB/LBU select `mem_rdata` lane `addr_lo`: 00→[31:24], 01→[23:16], 10→[15:8], 11→[7:0].
  - LH/LHU: addr_lo 00→[31:16], 10→[15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Misaligned access:
  - Conditions: LH/LHU with addr_lo[0]=1, LW with addr_lo≠00, or a reserved load_op.
  - On capture: `wb_we`=0, `wb_wdata`=0, `wb_misalign`=1.
- Non-load: `wb_wdata` = `mem_wdata`.
- Alignment is combinational ahead of the register; every output is registered.
- Per-edge update priority (first match wins):
  1. `rst`: all outputs to 0, `retire_cnt` to 0.
  2. `flush`: insert bubble. All enables, data and addresses go to 0, `wb_misalign`=0. Counter unchanged.
  3. `stall_mem`=1 and `stall_wb`=0: insert bubble, same as flush.
  4. `stall_wb`=1: hold all outputs and the counter.
  5. Otherwise: capture.
     - `wb_we` = `mem_we` & `mem_valid` & ~misaligned.
     - `wb_hilo_we` = `mem_hilo_we` & `mem_valid`.
     - Copy address and data.
     - `retire_cnt` += 1 if `mem_valid`.
- `mem_valid`=0 on capture forces `wb_we` and `wb_hilo_we` to 0. Data fields are still copied and are don't-care.
- A write to GPR 0 is forwarded unchanged; the register file discards it.
- `retire_cnt` wraps from 2^RETIRE_W−1 to 0 without a flag.

## Timing
- Latency is 1 cycle. An instruction present in MEM at edge N appears on the `wb_*` outputs after edge N and holds until edge N+1.
- The register file commits `wb_*` on the following falling edge, i.e. half a cycle after capture.
- The register file bypasses same-cycle reads from these outputs, so `wb_*` must be glitch-free register outputs with no combinational path from inputs.
- `wb_misalign` is asserted for exactly the cycle(s) the misaligned instruction occupies WB. If `stall_wb` holds that instruction, `wb_misalign` stays asserted.
- Reset asserted mid-stall or mid-flush clears everything on that edge. The first capture can occur on the first edge with `rst`=0.
- When `flush` and `stall_wb` are high together, flush wins and a bubble is inserted.

## Test plan
- Reset: `rst`=1 for 2 edges with random inputs → all outputs 0, `retire_cnt`=0. Release, capture `mem_we`=1, `waddr`=5, `wdata`=0x1234_5678 → next cycle `wb_we`=1, `wb_waddr`=5, `wb_wdata`=0x1234_5678, `retire_cnt`=1.
- Loads with `mem_rdata`=0x80FF_7F01:
  - LB, addr_lo 00 → 0xFFFF_FF80.
  - LBU, addr_lo 01 → 0x0000_00FF.
  - LB, addr_lo 10 → 0x0000_007F.
  - LH, addr_lo 00 → 0xFFFF_80FF.
  - LHU, addr_lo 10 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
- Misalignment: LW with addr_lo=01, `mem_we`=1 → `wb_we`=0, `wb_misalign`=1, `retire_cnt` still increments. A following aligned instruction clears `wb_misalign`.
- Stalls:
  - `stall_mem`=1, `stall_wb`=0 → `wb_we`=0, `wb_hilo_we`=0, counter unchanged.
  - `stall_mem`=`stall_wb`=1 for 3 cycles → outputs held bit-exact, then capture resumes.
- Flush priority: `flush`=1 with `stall_wb`=1 and a valid HI/LO write pending → bubble, `wb_hilo_we`=0.
- Counter wrap: preload via 2^32−1 valid captures (or force) → the next valid capture gives `retire_cnt`=0.
